// File: rtl/noc_injector_pkg.sv
// Shared definitions for the NoC packet injector and its matching ejector:
// FSM state encoding and header-field extraction helpers.
package noc_injector_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    // Widest flit the header helpers can decode.
    localparam int HDR_MAXW = 64;

    // Mask of the low w bits.
    function automatic logic [HDR_MAXW-1:0] field_mask(input int unsigned w);
        return (HDR_MAXW'(1) << w) - HDR_MAXW'(1);
    endfunction

    // Destination node number: the top dw bits of the header.
    function automatic int unsigned hdr_dest(input logic [HDR_MAXW-1:0] flit,
                                             input int unsigned fw,
                                             input int unsigned dw);
        logic [HDR_MAXW-1:0] tmp;
        tmp = (flit >> (fw - dw)) & field_mask(dw);
        return tmp[31:0];
    endfunction

    // Source node number: the dw bits just below the destination field.
    function automatic int unsigned hdr_src(input logic [HDR_MAXW-1:0] flit,
                                            input int unsigned fw,
                                            input int unsigned dw);
        logic [HDR_MAXW-1:0] tmp;
        tmp = (flit >> (fw - 2 * dw)) & field_mask(dw);
        return tmp[31:0];
    endfunction

    // Payload length: the low lw bits of the header.
    function automatic int unsigned hdr_len(input logic [HDR_MAXW-1:0] flit,
                                            input int unsigned lw);
        logic [HDR_MAXW-1:0] tmp;
        tmp = flit & field_mask(lw);
        return tmp[31:0];
    endfunction

endpackage

// File: rtl/noc_injector_outreg.sv
// Single-stage valid/ready output register. The parent only asserts i_load
// when the stage is empty or being drained this cycle, so no flit is lost
// and a full stream runs at one flit per cycle.
module noc_injector_outreg #(
    parameter int FLIT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic [FLIT_WIDTH-1:0] i_flit,
    input  logic                  i_last,
    input  logic                  i_ready,
    output logic [FLIT_WIDTH-1:0] o_flit,
    output logic                  o_last,
    output logic                  o_valid
);

    logic [FLIT_WIDTH-1:0] r_flit;
    logic                  r_last;
    logic                  r_valid;

    // Capture a new flit on load, otherwise empty the stage once it is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flit  <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_flit  <= i_flit;
            r_last  <= i_last;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_flit  = r_flit;
    assign o_last  = r_last;
    assign o_valid = r_valid;

endmodule

// File: rtl/noc_packet_injector.sv
// Tile-side packet source for the 2D mesh NoC. Accepts a request carrying
// destination coordinates and a payload length, then emits a header flit
// followed by the payload flits into one local mesh input channel.
module noc_packet_injector
    import noc_injector_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int X          = 2,
    parameter int Y          = 2,
    parameter int NODES      = X * Y,
    parameter int SRC_NODE   = 0,
    parameter int MAX_LEN    = 16,
    localparam int DW        = (NODES > 1) ? $clog2(NODES) : 1,
    localparam int LW        = $clog2(MAX_LEN + 1),
    localparam int XW        = (X > 1) ? $clog2(X) : 1,
    localparam int YW        = (Y > 1) ? $clog2(Y) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [XW-1:0]         req_dest_x,
    input  logic [YW-1:0]         req_dest_y,
    input  logic [LW-1:0]         req_len,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  err_dest
);

    // The header must hold destination, source and length without overlap.
    generate
        if (2 * DW + LW > FLIT_WIDTH) begin : g_bad_header_cfg
            $error("noc_packet_injector: header fields do not fit in FLIT_WIDTH");
        end
    endgenerate

    // Limits sized one bit wider than the request fields so that
    // out-of-range coordinates compare correctly.
    localparam logic [XW:0]    X_LIM   = X[XW:0];
    localparam logic [YW:0]    Y_LIM   = Y[YW:0];
    localparam logic [LW-1:0]  LEN_MAX = MAX_LEN[LW-1:0];
    localparam logic [DW-1:0]  X_MUL   = X[DW-1:0];
    localparam logic [DW-1:0]  SRC_ID  = SRC_NODE[DW-1:0];

    state_t                r_state;
    logic [DW-1:0]         r_dest;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_remaining;
    logic                  r_err_dest;

    logic                  w_req_fire;
    logic                  w_req_bad;
    logic [DW-1:0]         w_dest_node;
    logic                  w_out_free;
    logic                  w_data_fire;
    logic                  w_hdr_load;
    logic                  w_load;
    logic [FLIT_WIDTH-1:0] w_header;
    logic [FLIT_WIDTH-1:0] w_load_flit;
    logic                  w_load_last;
    logic                  w_out_valid;

    assign req_ready   = (r_state == IDLE);
    assign w_req_fire  = req_valid && req_ready;
    assign w_req_bad   = ({1'b0, req_dest_x} >= X_LIM) ||
                         ({1'b0, req_dest_y} >= Y_LIM) ||
                         (req_len > LEN_MAX);
    assign w_dest_node = DW'(req_dest_x) + DW'(req_dest_y) * X_MUL;

    // The output stage can take a flit if it is empty or drains this cycle.
    assign w_out_free  = !w_out_valid || out_ready;
    assign data_ready  = (r_state == PAYLOAD) && w_out_free;
    assign w_data_fire = data_valid && data_ready;
    assign w_hdr_load  = (r_state == HEADER) && w_out_free;
    assign w_load      = w_hdr_load || w_data_fire;

    // Assemble the header from the latched request; unused bits stay zero.
    always_comb begin
        w_header                          = '0;
        w_header[FLIT_WIDTH-1 -: DW]      = r_dest;
        w_header[FLIT_WIDTH-1-DW -: DW]   = SRC_ID;
        w_header[LW-1:0]                  = r_len;
    end

    // Choose what goes into the output stage: header in HEADER, payload otherwise.
    always_comb begin
        w_load_flit = data_in;
        w_load_last = (r_remaining == LW'(1));
        if (r_state == HEADER) begin
            w_load_flit = w_header;
            w_load_last = (r_len == '0);
        end
    end

    // Packet sequencing: validate and latch requests, then count payload flits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dest      <= '0;
            r_len       <= '0;
            r_remaining <= '0;
            r_err_dest  <= 1'b0;
        end else begin
            r_err_dest <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        if (w_req_bad) begin
                            r_err_dest <= 1'b1;
                        end else begin
                            r_dest      <= w_dest_node;
                            r_len       <= req_len;
                            r_remaining <= req_len;
                            r_state     <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (w_out_free) begin
                        r_state <= (r_len == '0) ? IDLE : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (w_data_fire) begin
                        r_remaining <= r_remaining - LW'(1);
                        if (r_remaining == LW'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    noc_injector_outreg #(
        .FLIT_WIDTH (FLIT_WIDTH)
    ) u_outreg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_flit  (w_load_flit),
        .i_last  (w_load_last),
        .i_ready (out_ready),
        .o_flit  (out_flit),
        .o_last  (out_last),
        .o_valid (w_out_valid)
    );

    assign out_valid = w_out_valid;
    assign busy      = (r_state != IDLE) || w_out_valid;
    assign err_dest  = r_err_dest;

endmodule

// File: tb/tb_noc_packet_injector.sv
// Self-checking bench for noc_packet_injector on a 3x2 mesh, source node 4.
module tb_noc_packet_injector;

    localparam int FW  = 32;
    localparam int XN  = 3;
    localparam int YN  = 2;
    localparam int SRC = 4;
    localparam int ML  = 16;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_dest_x;
    logic [0:0]  req_dest_y;
    logic [4:0]  req_len;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] out_flit;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err_dest;

    noc_packet_injector #(
        .FLIT_WIDTH (FW),
        .X          (XN),
        .Y          (YN),
        .SRC_NODE   (SRC),
        .MAX_LEN    (ML)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dest_x (req_dest_x),
        .req_dest_y (req_dest_y),
        .req_len    (req_len),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .out_flit   (out_flit),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err_dest   (err_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int err_cnt     = 0;
    int dr_seen     = 0;
    bit d_fire      = 1'b0;
    bit src_gaps    = 1'b0;
    bit rnd_ready   = 1'b0;

    logic [31:0] got_flit[$];
    logic        got_last[$];
    int          got_cyc[$];
    logic [31:0] exp_flit[$];
    logic        exp_last[$];
    logic [31:0] pay_q[$];

    logic [31:0] prev_flit;
    logic        prev_last;
    bit          prev_stall = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer on the falling edge: collects delivered flits, checks that a
    // stalled flit holds, and notes payload handshakes and error pulses.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            d_fire     = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (out_valid !== 1'b1 || out_flit !== prev_flit || out_last !== prev_last) begin
                    miscompares++;
                    $display("FAIL stall_hold: got v=%b %h/%b, need v=1 %h/%b",
                             out_valid, out_flit, out_last, prev_flit, prev_last);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_flit  = out_flit;
            prev_last  = out_last;
            if (out_valid && out_ready) begin
                got_flit.push_back(out_flit);
                got_last.push_back(out_last);
                got_cyc.push_back(cyc);
            end
            d_fire = data_valid && data_ready;
            if (err_dest) err_cnt++;
            if (data_ready) dr_seen++;
        end
    end

    // Payload source: offers the head of pay_q, optionally with random gaps.
    initial begin
        data_valid = 1'b0;
        data_in    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (d_fire) begin
                if (pay_q.size() > 0) pay_q.delete(0);
                d_fire = 1'b0;
            end
            data_valid = (pay_q.size() > 0) && (!src_gaps || ($urandom_range(3) != 0));
            data_in    = (pay_q.size() > 0) ? pay_q[0] : 32'h0;
        end
    end

    // Reference header: destination node, source node and length fields.
    function automatic logic [31:0] model_hdr(input int unsigned dx, input int unsigned dy,
                                              input int unsigned len);
        int unsigned node;
        node = dx + dy * XN;
        return 32'(node << 29) | 32'(SRC << 26) | 32'(len);
    endfunction

    // Queue a valid packet: payload into the source, all flits into the model.
    function automatic void model_packet(input int unsigned dx, input int unsigned dy,
                                         input int unsigned len, input bit fixed);
        logic [31:0] v;
        exp_flit.push_back(model_hdr(dx, dy, len));
        exp_last.push_back(len == 0);
        for (int i = 0; i < int'(len); i++) begin
            v = fixed ? 32'(32'hA + i) : $urandom;
            pay_q.push_back(v);
            exp_flit.push_back(v);
            exp_last.push_back(i == int'(len) - 1);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        got_flit.delete();
        got_last.delete();
        got_cyc.delete();
        exp_flit.delete();
        exp_last.delete();
    endtask

    // Present a request and hold it until an accepting edge; acc = that edge.
    task automatic issue_req(input int dx, input int dy, input int len, output int acc);
        req_dest_x = dx[1:0];
        req_dest_y = dy[0:0];
        req_len    = len[4:0];
        req_valid  = 1'b1;
        acc        = -1;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                tick();
                acc = cyc;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
        if (acc < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL req_accept: got no accept in 200 cycles, need accept");
        end
    endtask

    task automatic wait_flits(input int n);
        for (int i = 0; i < 600; i++) begin
            if (got_flit.size() >= n) begin
                out_ready = 1'b1;
                return;
            end
            if (rnd_ready) out_ready = ($urandom_range(3) != 0);
            tick();
        end
        out_ready = 1'b1;
        vectors++;
        miscompares++;
        $display("FAIL flit_count: got %0d flits, need %0d", got_flit.size(), n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || out_flit !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_out: got v=%b l=%b f=%h, need 0/0/0", out_valid, out_last, out_flit);
        end
        vectors++;
        if (err_dest !== 1'b0 || data_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got err=%b dr=%b busy=%b, need 0/0/0", err_dest, data_ready, busy);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_req_ready: got %b, need 1", req_ready);
        end
        tick();
    endtask

    task automatic test_basic();
        int acc;
        clear_obs();
        model_packet(2, 1, 3, 1'b1);
        issue_req(2, 1, 3, acc);
        wait_flits(4);
        tick();
        vectors++;
        if (got_flit[0] !== 32'hB0000003) begin
            miscompares++;
            $display("FAIL basic_header: got %h, need b0000003", got_flit[0]);
        end
        vectors++;
        if (got_cyc[0] !== acc + 1) begin
            miscompares++;
            $display("FAIL basic_latency: got cycle %0d, need %0d", got_cyc[0], acc + 1);
        end
        for (int i = 0; i < exp_flit.size(); i++) begin
            vectors++;
            if (i >= got_flit.size() || got_flit[i] !== exp_flit[i] || got_last[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL basic_flit%0d: got %h/%b, need %h/%b", i, got_flit[i], got_last[i],
                         exp_flit[i], exp_last[i]);
            end
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy: got %b, need 0", busy);
        end
    endtask

    task automatic test_zero_len();
        int acc;
        int dr0;
        clear_obs();
        dr0 = dr_seen;
        model_packet(0, 0, 0, 1'b0);
        issue_req(0, 0, 0, acc);
        wait_flits(1);
        tick();
        tick();
        vectors++;
        if (got_flit.size() !== 1 || got_flit[0] !== 32'h10000000 || got_last[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_len_flit: got n=%0d %h/%b, need n=1 10000000/1",
                     got_flit.size(), got_flit[0], got_last[0]);
        end
        vectors++;
        if (dr_seen !== dr0) begin
            miscompares++;
            $display("FAIL zero_len_data_ready: got %0d ready cycles, need 0", dr_seen - dr0);
        end
    endtask

    task automatic test_bad_dest();
        int acc;
        int e0;
        int ls[2];
        int xs[2];
        ls[0] = 2;  xs[0] = 3;
        ls[1] = 17; xs[1] = 1;
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            e0 = err_cnt;
            issue_req(xs[k], k, ls[k], acc);
            vectors++;
            if (err_dest !== 1'b1 || req_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL bad%0d_pulse: got err=%b rr=%b v=%b, need 1/1/0", k, err_dest,
                         req_ready, out_valid);
            end
            tick();
            vectors++;
            if (err_dest !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL bad%0d_after: got err=%b v=%b busy=%b, need 0/0/0", k, err_dest,
                         out_valid, busy);
            end
            tick();
            tick();
            vectors++;
            if (err_cnt - e0 !== 1 || got_flit.size() !== 0) begin
                miscompares++;
                $display("FAIL bad%0d_count: got %0d pulses %0d flits, need 1 pulse 0 flits", k,
                         err_cnt - e0, got_flit.size());
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        logic [31:0] hold;
        clear_obs();
        model_packet(1, 1, 4, 1'b0);
        issue_req(1, 1, 4, acc);
        for (int i = 0; i < 50 && got_flit.size() < 2; i++) tick();
        out_ready = 1'b0;
        hold = exp_flit[2];
        #1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_flit !== hold || data_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold%0d: got v=%b f=%h dr=%b, need 1 %h 0", k, out_valid,
                         out_flit, data_ready, hold);
            end
            tick();
        end
        out_ready = 1'b1;
        wait_flits(5);
        tick();
        for (int i = 0; i < exp_flit.size(); i++) begin
            vectors++;
            if (i >= got_flit.size() || got_flit[i] !== exp_flit[i] || got_last[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL bp_flit%0d: got %h/%b, need %h/%b", i, got_flit[i], got_last[i],
                         exp_flit[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        clear_obs();
        model_packet(2, 0, 4, 1'b0);
        issue_req(2, 0, 4, acc);
        for (int i = 0; i < 50 && got_flit.size() < 2; i++) tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_flit !== 32'h0 || data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got v=%b busy=%b f=%h dr=%b, need 0/0/0/0", out_valid, busy,
                     out_flit, data_ready);
        end
        tick();
        #1;
        pay_q.delete();
        clear_obs();
        tick();
        rst = 1'b0;
        tick();
        model_packet(1, 0, 1, 1'b0);
        issue_req(1, 0, 1, acc);
        wait_flits(2);
        tick();
        vectors++;
        if (got_flit[0] !== 32'h30000001) begin
            miscompares++;
            $display("FAIL rst_mid_header: got %h, need 30000001", got_flit[0]);
        end
        for (int i = 0; i < exp_flit.size(); i++) begin
            vectors++;
            if (i >= got_flit.size() || got_flit[i] !== exp_flit[i] || got_last[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL rst_mid_flit%0d: got %h/%b, need %h/%b", i, got_flit[i], got_last[i],
                         exp_flit[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc_a;
        int acc_b;
        clear_obs();
        model_packet(0, 1, 1, 1'b0);
        model_packet(2, 0, 1, 1'b0);
        issue_req(0, 1, 1, acc_a);
        issue_req(2, 0, 1, acc_b);
        wait_flits(4);
        tick();
        for (int i = 0; i < exp_flit.size(); i++) begin
            vectors++;
            if (i >= got_flit.size() || got_flit[i] !== exp_flit[i] || got_last[i] !== exp_last[i]) begin
                miscompares++;
                $display("FAIL b2b_flit%0d: got %h/%b, need %h/%b", i, got_flit[i], got_last[i],
                         exp_flit[i], exp_last[i]);
            end
        end
        vectors++;
        if (got_cyc[1] - got_cyc[0] !== 1 || got_cyc[2] - got_cyc[1] !== 2 ||
            got_cyc[3] - got_cyc[2] !== 1) begin
            miscompares++;
            $display("FAIL b2b_spacing: got gaps %0d,%0d,%0d, need 1,2,1", got_cyc[1] - got_cyc[0],
                     got_cyc[2] - got_cyc[1], got_cyc[3] - got_cyc[2]);
        end
    endtask

    task automatic test_random();
        int acc;
        int e0;
        int dx;
        int dy;
        int len;
        bit bad;
        src_gaps  = 1'b1;
        rnd_ready = 1'b1;
        for (int p = 0; p < 24; p++) begin
            dx  = $urandom_range(0, 3);
            dy  = $urandom_range(0, 1);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 31) : $urandom_range(0, ML);
            bad = (dx >= XN) || (len > ML);
            clear_obs();
            e0 = err_cnt;
            if (!bad) model_packet(dx, dy, len, 1'b0);
            issue_req(dx, dy, len, acc);
            if (bad) begin
                tick();
                tick();
                vectors++;
                if (err_cnt - e0 !== 1 || got_flit.size() !== 0) begin
                    miscompares++;
                    $display("FAIL rnd%0d_drop: got %0d pulses %0d flits, need 1 pulse 0 flits", p,
                             err_cnt - e0, got_flit.size());
                end
            end else begin
                wait_flits(len + 1);
                tick();
                vectors++;
                if (err_cnt !== e0 || got_flit.size() !== len + 1) begin
                    miscompares++;
                    $display("FAIL rnd%0d_count: got %0d pulses %0d flits, need 0 pulses %0d flits",
                             p, err_cnt - e0, got_flit.size(), len + 1);
                end
                for (int i = 0; i < exp_flit.size(); i++) begin
                    vectors++;
                    if (i >= got_flit.size() || got_flit[i] !== exp_flit[i] ||
                        got_last[i] !== exp_last[i]) begin
                        miscompares++;
                        $display("FAIL rnd%0d_flit%0d: got %h/%b, need %h/%b", p, i, got_flit[i],
                                 got_last[i], exp_flit[i], exp_last[i]);
                    end
                end
            end
        end
        src_gaps  = 1'b0;
        rnd_ready = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_dest_x = '0;
        req_dest_y = '0;
        req_len    = '0;
        out_ready  = 1'b1;
        test_reset();
        test_basic();
        test_zero_len();
        test_bad_dest();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion by 500000 ns, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
